// File: rtl/kogge_pipe_addsub.sv
// Pipelined Kogge-Stone adder/subtractor with one register per prefix level.
// Valid/ready on both sides; the whole pipe freezes while the output is stalled.
module kogge_pipe_addsub #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   input  logic         Sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   Sum,
   output logic         Ovf
);
   localparam int L = $clog2(N);

   logic         stall;
   logic         adv;
   logic         acc;
   logic [N-1:0] bx;
   logic [N-1:0] g_in;
   logic [N-1:0] p_in;
   logic [N-1:0] gg [0:L];
   logic [N-1:0] pp [0:L-1];
   logic [N-1:0] gn [0:L-1];
   logic [N-1:0] pn [0:L-1];
   logic [N-1:0] pv [0:L];
   logic         am [0:L];
   logic         bm [0:L];
   logic         vv [0:L];
   logic [N:0]   sum_n;
   logic         ovf_n;

   assign stall    = out_valid && !out_ready;
   assign adv      = !stall;
   assign in_ready = !rst && !stall;
   assign acc      = in_valid && in_ready;
   assign bx       = Sub ? ~B : B;

   // Prefix vector is shifted up one place: position 0 is the carry-in as a pure generate,
   // so after the last level position i holds the carry into operand bit i.
   always_comb begin
      g_in    = '0;
      p_in    = '0;
      g_in[0] = Sub ? 1'b1 : Cin;
      for (int j = 1; j < N; j++) begin
         g_in[j] = A[j-1] & bx[j-1];
         p_in[j] = A[j-1] ^ bx[j-1];
      end
   end

   always_comb begin
      for (int k = 0; k < L; k++) begin
         gn[k] = gg[k];
         pn[k] = pp[k];
         for (int j = (1 << k); j < N; j++) begin
            gn[k][j] = gg[k][j] | (pp[k][j] & gg[k][j - (1 << k)]);
            pn[k][j] = pp[k][j] & pp[k][j - (1 << k)];
         end
      end
   end

   // Carry-out needs the top bit's own generate/propagate on top of the carry into it.
   always_comb begin
      sum_n[N-1:0] = pv[L] ^ gg[L];
      sum_n[N]     = (am[L] & bm[L]) | (pv[L][N-1] & gg[L][N-1]);
      ovf_n        = (am[L] == bm[L]) && (sum_n[N-1] != am[L]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s <= L; s++) begin
            vv[s] <= 1'b0;
         end
         out_valid <= 1'b0;
         Sum       <= '0;
         Ovf       <= 1'b0;
      end else if (adv) begin
         vv[0] <= acc;
         gg[0] <= g_in;
         pp[0] <= p_in;
         pv[0] <= A ^ bx;
         am[0] <= A[N-1];
         bm[0] <= bx[N-1];
         for (int k = 0; k < L; k++) begin
            vv[k+1] <= vv[k];
            gg[k+1] <= gn[k];
            pv[k+1] <= pv[k];
            am[k+1] <= am[k];
            bm[k+1] <= bm[k];
         end
         for (int k = 0; k < L - 1; k++) begin
            pp[k+1] <= pn[k];
         end
         out_valid <= vv[L];
         Sum       <= sum_n;
         Ovf       <= ovf_n;
      end
   end

endmodule

// File: tb/tb_kogge_pipe_addsub.sv
// Bench for kogge_pipe_addsub: directed N=8 tests plus random streams at N=8/16/12,
// all results checked against an arithmetic scoreboard in acceptance order.
module tb_kogge_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h time=%0t", tag, got, exp, $time);
      end
   endtask

   // directed DUT, N=8
   logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, ovf;
   logic [7:0] a, b;
   logic [8:0] sum;
   logic [9:0] q8 [$];
   logic [9:0] e8, hv8;
   logic       hold8 = 1'b0;
   logic       took8 = 1'b0;
   int         n_pop8 = 0;

   kogge_pipe_addsub #(.N(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Cin(cin), .Sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Ovf(ovf)
   );

   function automatic logic [9:0] model8(input logic [7:0] ma, mb, input logic mc, ms);
      logic [7:0] mbx;
      logic [8:0] r;
      mbx = ms ? ~mb : mb;
      r   = {1'b0, ma} + {1'b0, mbx} + {8'b0, (ms ? 1'b1 : mc)};
      return {(ma[7] == mbx[7]) && (r[7] != ma[7]), r};
   endfunction

   always @(negedge clk) begin
      if (hold8) check("hold", {out_valid, ovf, sum}, {1'b1, hv8});
      hold8 = !rst && out_valid && !out_ready;
      hv8   = {ovf, sum};
      if (rst) begin
         q8.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("sb_nonempty", q8.size() != 0, 1);
            if (q8.size() != 0) begin
               e8 = q8.pop_front();
               check("sb_sum", sum, e8[8:0]);
               check("sb_ovf", ovf, e8[9]);
               n_pop8++;
            end
         end
         if (in_valid && in_ready) q8.push_back(model8(a, b, cin, sub));
      end
      took8 = in_valid && in_ready;
   end

   task automatic drv(input logic v, input logic [7:0] xa, xb, input logic xc, xs);
      @(posedge clk);
      #1;
      in_valid = v; a = xa; b = xb; cin = xc; sub = xs;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
      check(tag, q8.size(), 0);
   endtask

   // random streams at three widths
   for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
      localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 16 : 12);
      logic         rr, iv, ir, c, s, ov, ordy, o;
      logic [W-1:0] x, y;
      logic [W:0]   sm;
      logic [W+1:0] q [$];
      logic [W+1:0] e, hv;
      logic         took, hold, done;
      int           nacc, npop;

      kogge_pipe_addsub #(.N(W)) u_dut (
         .clk(clk), .rst(rr), .in_valid(iv), .in_ready(ir),
         .A(x), .B(y), .Cin(c), .Sub(s),
         .out_valid(ov), .out_ready(ordy), .Sum(sm), .Ovf(o)
      );

      function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic mc, ms);
         logic [W-1:0] mbx;
         logic [W:0]   r;
         mbx = ms ? ~mb : mb;
         r   = {1'b0, ma} + {1'b0, mbx} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
         return {(ma[W-1] == mbx[W-1]) && (r[W-1] != ma[W-1]), r};
      endfunction

      initial begin
         rr = 1'b1; iv = 1'b0; ordy = 1'b0; x = '0; y = '0; c = 1'b0; s = 1'b0;
         took = 1'b0; hold = 1'b0; done = 1'b0; nacc = 0; npop = 0;
         repeat (3) @(posedge clk);
         #1 rr = 1'b0;
         for (int t = 0; t < 60000 && npop < 10001; t++) begin
            @(posedge clk);
            #1;
            if (!iv || took) begin
               iv = (nacc < 10001) && ($urandom_range(0, 3) != 0);
               x  = W'($urandom);
               y  = W'($urandom);
               c  = 1'($urandom_range(0, 1));
               s  = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 3) != 0);
         end
         check($sformatf("rnd%0d_delivered", W), npop, 10001);
         check($sformatf("rnd%0d_leftover", W), q.size(), 0);
         done = 1'b1;
      end

      always @(negedge clk) begin
         if (!rr) begin
            if (hold) check($sformatf("rnd%0d_hold", W), {ov, o, sm}, {1'b1, hv});
            check($sformatf("rnd%0d_in_ready", W), ir, !(ov && !ordy));
            if (ov && ordy) begin
               check($sformatf("rnd%0d_nonempty", W), q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check($sformatf("rnd%0d_sum", W), sm, e[W:0]);
                  check($sformatf("rnd%0d_ovf", W), o, e[W+1]);
                  npop++;
               end
            end
            if (iv && ir) begin
               q.push_back(model(x, y, c, s));
               nacc++;
            end
         end
         hold = !rr && ov && !ordy;
         hv   = {o, sm};
         took = iv && ir;
      end
   end

   initial begin
      int   c0, lat, first, last, cnt, hold_n, k, nstall, pops0;
      logic seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum_ovf", {ovf, sum}, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // single beat, latency
      drv(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      c0 = cyc;
      check("lat_accept", in_ready, 1);
      drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge clk);
         if (out_valid) lat = cyc - c0;
      end
      check("lat_cycles", lat, 5);
      @(negedge clk);
      check("lat_single_pulse", out_valid, 0);

      // subtract, overflow and boundary beats (Cin=1 on a subtract must be ignored)
      drv(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
      drv(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
      drv(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
      drv(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
      drv(1'b1, 8'hA5, 8'h00, 1'b0, 1'b1);
      drv(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
      drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drain("sub_drain");

      // ten back-to-back beats
      first = -1; last = -1; cnt = 0;
      for (int t = 0; t < 25; t++) begin
         if (t < 10) drv(1'b1, 8'(t), 8'(2 * t), 1'(t % 2), 1'b0);
         else        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         @(negedge clk);
         if (t < 10) check("b2b_in_ready", in_ready, 1);
         if (out_valid) begin
            if (cnt == 0) first = t;
            last = t;
            cnt++;
         end
      end
      check("b2b_count", cnt, 10);
      check("b2b_first", first, 5);
      check("b2b_span", last - first, 9);

      // backpressure: out_ready low for 3 cycles once the first result shows
      pops0 = n_pop8; k = 0; seen = 1'b0; hold_n = 0; nstall = 0;
      for (int t = 0; t < 40; t++) begin
         @(posedge clk);
         #1;
         if (in_valid && took8) k++;
         if (out_valid && !seen) begin
            seen   = 1'b1;
            hold_n = 3;
         end
         out_ready = (hold_n == 0);
         if (hold_n > 0) hold_n--;
         in_valid = (k < 6);
         a   = 8'(k * 37 + 5);
         b   = 8'(k * 11 + 200);
         cin = k[0];
         sub = k[1];
         @(negedge clk);
         if (!out_ready) begin
            nstall++;
            check("stall_in_ready", in_ready, 0);
         end
      end
      check("stall_cycles", nstall, 3);
      check("stall_delivered", n_pop8 - pops0, 6);
      check("stall_sb_empty", q8.size(), 0);

      // reset with three beats in flight; operands offered during reset must be dropped
      for (int i = 0; i < 3; i++) drv(1'b1, 8'(i + 1), 8'(i + 9), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'h22;
      @(negedge clk);
      check("rst_mid_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_sum_ovf", {ovf, sum}, 0);
      check("rst_mid_in_ready_back", in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst_quiet", out_valid, 0);
      end

      for (int i = 0; i < 70000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); i++)
         @(negedge clk);
      check("rnd_finished", g_rnd[0].done && g_rnd[1].done && g_rnd[2].done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
